permute_dispatch: RTL and testbench

- RF/FWD-side initiator for the permute pipe: accepts decoded instructions, reads the 128x128-bit register file, and drives the permute pipe's instruction inputs (op, format, rt_addr, ra, rb, imm, reg_write).
- Owns the register-file write port for the permute pipe's WB outputs, including same-cycle write-to-read bypass.
- Keeps a per-register pending scoreboard and stalls issue on RAW/WAW hazards against in-flight permute results.

---
 rtl/spu_pkg.sv | 26 ++
 rtl/spu_scoreboard.sv | 49 ++++
 rtl/permute_dispatch.sv | 110 +++++++++++
 tb/tb_permute_dispatch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared constants and the decoded-instruction bundle for the SPU permute dispatch path.
package spu_pkg;

    localparam int REG_COUNT    = 128;
    localparam int ADDR_W       = 7;
    localparam int DATA_W       = 128;
    localparam int OP_W         = 11;
    localparam int IMM_W        = 18;
    localparam int FMT_W        = 3;
    localparam int MAX_INFLIGHT = 4;
    localparam int INFL_W       = 3;

    localparam logic [OP_W-1:0]  NOP_OP  = '0;
    localparam logic [FMT_W-1:0] NOP_FMT = '0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [FMT_W-1:0]  format;
        logic [ADDR_W-1:0] rt_addr;
        logic [ADDR_W-1:0] ra_addr;
        logic [ADDR_W-1:0] rb_addr;
        logic [IMM_W-1:0]  imm;
        logic              reg_write;
    } dispatch_instr_t;

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register pending bits and in-flight counter for the permute pipe; an issue
// that sets a register wins over a writeback clearing it in the same cycle.
module spu_scoreboard
    import spu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_en_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    output logic [REG_COUNT-1:0] pend_eff_o,
    output logic [INFL_W-1:0]    inflight_o
);

    localparam logic [REG_COUNT-1:0] ONE = {{(REG_COUNT-1){1'b0}}, 1'b1};

    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic [REG_COUNT-1:0] set_mask, clr_mask;
    logic [INFL_W-1:0]    inflight_q, inflight_d;

    always_comb begin
        set_mask   = set_en_i ? (ONE << set_addr_i) : '0;
        clr_mask   = clr_en_i ? (ONE << clr_addr_i) : '0;
        pend_eff_o = pending_q & ~clr_mask;
        pending_d  = pend_eff_o | set_mask;

        inflight_d = inflight_q;
        if (set_en_i && !clr_en_i) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (!set_en_i && clr_en_i) begin
            // Stray writebacks (e.g. from before a reset) must not wrap the count.
            inflight_d = (inflight_q != '0) ? inflight_q - INFL_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q  <= '0;
            inflight_q <= '0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;

endmodule

// File: rtl/permute_dispatch.sv
// Register-file front end of the permute pipe: operand read with WB bypass,
// hazard stall against in-flight results, and one-cycle registered issue.
module permute_dispatch
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [FMT_W-1:0]  in_format,
    input  logic [ADDR_W-1:0] in_ra_addr,
    input  logic [ADDR_W-1:0] in_rb_addr,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_reg_write,
    output logic [OP_W-1:0]   op,
    output logic [FMT_W-1:0]  format,
    output logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb,
    output logic [IMM_W-1:0]  imm,
    output logic              reg_write,
    input  logic [DATA_W-1:0] rt_wb,
    input  logic [ADDR_W-1:0] rt_addr_wb,
    input  logic              reg_write_wb,
    output logic [INFL_W-1:0] inflight
);

    dispatch_instr_t      in_instr;
    logic [DATA_W-1:0]    regfile_q [REG_COUNT];
    logic [DATA_W-1:0]    ra_d, rb_d;
    logic [REG_COUNT-1:0] pend_eff;
    logic                 hz, accept;

    logic [OP_W-1:0]      op_q;
    logic [FMT_W-1:0]     format_q;
    logic [ADDR_W-1:0]    rt_addr_q;
    logic [DATA_W-1:0]    ra_q, rb_q;
    logic [IMM_W-1:0]     imm_q;
    logic                 reg_write_q;

    assign in_instr = '{op: in_op, format: in_format, rt_addr: in_rt_addr,
                        ra_addr: in_ra_addr, rb_addr: in_rb_addr, imm: in_imm,
                        reg_write: in_reg_write};

    always_comb begin
        ra_d = (reg_write_wb && rt_addr_wb == in_instr.ra_addr) ? rt_wb : regfile_q[in_instr.ra_addr];
        rb_d = (reg_write_wb && rt_addr_wb == in_instr.rb_addr) ? rt_wb : regfile_q[in_instr.rb_addr];

        // Full in-flight window only blocks writers; a WB this cycle frees a slot.
        hz = pend_eff[in_instr.ra_addr]
          || pend_eff[in_instr.rb_addr]
          || (in_instr.reg_write && pend_eff[in_instr.rt_addr])
          || (in_instr.reg_write && inflight == INFL_W'(MAX_INFLIGHT) && !reg_write_wb);

        in_ready = reset && !hz;
        accept   = in_valid && in_ready;
    end

    spu_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (accept && in_instr.reg_write),
        .set_addr_i (in_instr.rt_addr),
        .clr_en_i   (reg_write_wb),
        .clr_addr_i (rt_addr_wb),
        .pend_eff_o (pend_eff),
        .inflight_o (inflight)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (reg_write_wb) begin
            regfile_q[rt_addr_wb] <= rt_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || !accept) begin
            op_q        <= NOP_OP;
            format_q    <= NOP_FMT;
            rt_addr_q   <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
        end else begin
            op_q        <= in_instr.op;
            format_q    <= in_instr.format;
            rt_addr_q   <= in_instr.rt_addr;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            imm_q       <= in_instr.imm;
            reg_write_q <= in_instr.reg_write;
        end
    end

    assign op        = op_q;
    assign format    = format_q;
    assign rt_addr   = rt_addr_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign imm       = imm_q;
    assign reg_write = reg_write_q;

endmodule

// File: tb/tb_permute_dispatch.sv
// Directed bench for permute_dispatch: reset, bypass, RAW/WAW stalls, inflight limit, nops.
module tb_permute_dispatch;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [10:0]  in_op;
    logic [2:0]   in_format;
    logic [6:0]   in_ra_addr, in_rb_addr, in_rt_addr;
    logic [17:0]  in_imm;
    logic         in_reg_write;
    logic [10:0]  op;
    logic [2:0]   format;
    logic [6:0]   rt_addr;
    logic [127:0] ra, rb;
    logic [17:0]  imm;
    logic         reg_write;
    logic [127:0] rt_wb;
    logic [6:0]   rt_addr_wb;
    logic         reg_write_wb;
    logic [2:0]   inflight;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] V2 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
    localparam logic [127:0] V3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] V4 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] V5 = 128'h99998888_77776666_55554444_33332222;

    always #5 clk = ~clk;

    permute_dispatch dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_format    (in_format),
        .in_ra_addr   (in_ra_addr),
        .in_rb_addr   (in_rb_addr),
        .in_rt_addr   (in_rt_addr),
        .in_imm       (in_imm),
        .in_reg_write (in_reg_write),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .reg_write    (reg_write),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .inflight     (inflight)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] o, input logic [2:0] f,
                         input logic [6:0] a, input logic [6:0] b, input logic [6:0] t,
                         input logic [17:0] im, input logic w);
        in_valid = v; in_op = o; in_format = f; in_ra_addr = a; in_rb_addr = b;
        in_rt_addr = t; in_imm = im; in_reg_write = w;
    endtask

    task automatic wb(input logic en, input logic [6:0] a, input logic [127:0] d);
        reg_write_wb = en; rt_addr_wb = a; rt_wb = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        wb(1'b0, 7'd0, '0);
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset got %b exp 0", in_ready); end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({op, format, rt_addr, imm, reg_write} !== '0) begin
            errors++; $display("FAIL reset_outputs got op=%h fmt=%h rt=%h imm=%h rw=%b exp all 0", op, format, rt_addr, imm, reg_write);
        end
        checks++;
        if (ra !== '0 || rb !== '0) begin errors++; $display("FAIL reset_operands got ra=%h rb=%h exp 0", ra, rb); end
        checks++;
        if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_write_read();
        wb(1'b1, 7'd5, V1);
        step();
        wb(1'b0, 7'd0, '0);
        drive(1'b1, 11'h1A, 3'h3, 7'd5, 7'd0, 7'd33, 18'h21234, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", in_ready); end
        step();
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (ra !== V1 || rb !== '0) begin errors++; $display("FAIL wr_read got ra=%h rb=%h exp ra=%h rb=0", ra, rb, V1); end
        checks++;
        if (op !== 11'h1A || format !== 3'h3 || rt_addr !== 7'd33 || imm !== 18'h21234 || reg_write !== 1'b0) begin
            errors++; $display("FAIL wr_fields got op=%h fmt=%h rt=%0d imm=%h rw=%b exp 1a/3/33/21234/0", op, format, rt_addr, imm, reg_write);
        end
        step();
        checks++;
        if (op !== 11'h0 || ra !== '0) begin errors++; $display("FAIL wr_one_cycle got op=%h ra=%h exp 0", op, ra); end
        // writeback and issue in the same cycle: bypass on ra, regfile on rb
        wb(1'b1, 7'd9, V2);
        drive(1'b1, 11'h2B, 3'h1, 7'd9, 7'd5, 7'd40, 18'h00007, 1'b0);
        step();
        wb(1'b0, 7'd0, '0);
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (ra !== V2 || rb !== V1) begin errors++; $display("FAIL bypass got ra=%h rb=%h exp ra=%h rb=%h", ra, rb, V2, V1); end
    endtask

    task automatic test_raw();
        drive(1'b1, 11'h055, 3'h2, 7'd0, 7'd0, 7'd10, 18'h0, 1'b1);
        step();
        checks++;
        if (reg_write !== 1'b1 || rt_addr !== 7'd10 || inflight !== 3'd1) begin
            errors++; $display("FAIL raw_issue got rw=%b rt=%0d inflight=%0d exp 1/10/1", reg_write, rt_addr, inflight);
        end
        drive(1'b1, 11'h066, 3'h1, 7'd10, 7'd0, 7'd0, 18'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall cycle %0d got ready=%b exp 0", i, in_ready); end
            step();
            checks++;
            if (reg_write !== 1'b0 || op !== 11'h0) begin errors++; $display("FAIL raw_nop got op=%h rw=%b exp 0", op, reg_write); end
        end
        wb(1'b1, 7'd10, V3);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got ready=%b exp 1", in_ready); end
        step();
        wb(1'b0, 7'd0, '0);
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (ra !== V3 || op !== 11'h066 || inflight !== 3'd0) begin
            errors++; $display("FAIL raw_data got ra=%h op=%h inflight=%0d exp %h/066/0", ra, op, inflight, V3);
        end
    endtask

    task automatic test_waw();
        drive(1'b1, 11'h011, 3'h0, 7'd0, 7'd0, 7'd7, 18'h0, 1'b1);
        step();
        wb(1'b1, 7'd7, V4);
        drive(1'b1, 11'h012, 3'h0, 7'd0, 7'd0, 7'd7, 18'h0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_accept got ready=%b exp 1", in_ready); end
        step();
        wb(1'b0, 7'd0, '0);
        checks++;
        if (inflight !== 3'd1 || reg_write !== 1'b1) begin errors++; $display("FAIL waw_inflight got %0d rw=%b exp 1/1", inflight, reg_write); end
        drive(1'b1, 11'h013, 3'h0, 7'd7, 7'd0, 7'd0, 18'h0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_set_wins got ready=%b exp 0", in_ready); end
        step();
        wb(1'b1, 7'd7, V5);
        step();
        wb(1'b0, 7'd0, '0);
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (ra !== V5 || inflight !== 3'd0) begin errors++; $display("FAIL waw_clear got ra=%h inflight=%0d exp %h/0", ra, inflight, V5); end
    endtask

    task automatic test_inflight_limit();
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 11'h100, 3'h0, 7'd0, 7'd0, 7'(r), 18'h0, 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL lim_b2b rt=%0d got ready=%b exp 1", r, in_ready); end
            step();
        end
        checks++;
        if (inflight !== 3'd4) begin errors++; $display("FAIL lim_count got %0d exp 4", inflight); end
        drive(1'b1, 11'h101, 3'h0, 7'd0, 7'd0, 7'd6, 18'h0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL lim_stall got ready=%b exp 0", in_ready); end
        drive(1'b1, 11'h102, 3'h4, 7'd0, 7'd0, 7'd0, 18'h3, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lim_nonwriter got ready=%b exp 1", in_ready); end
        step();
        checks++;
        if (op !== 11'h102 || reg_write !== 1'b0 || inflight !== 3'd4) begin
            errors++; $display("FAIL lim_nonwriter_out got op=%h rw=%b inflight=%0d exp 102/0/4", op, reg_write, inflight);
        end
        drive(1'b1, 11'h101, 3'h0, 7'd0, 7'd0, 7'd6, 18'h0, 1'b1);
        wb(1'b1, 7'd1, V1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lim_release got ready=%b exp 1", in_ready); end
        step();
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (inflight !== 3'd4 || rt_addr !== 7'd6 || reg_write !== 1'b1) begin
            errors++; $display("FAIL lim_fifth got inflight=%0d rt=%0d rw=%b exp 4/6/1", inflight, rt_addr, reg_write);
        end
        for (int r = 2; r <= 6; r++) begin
            if (r == 5) continue;
            wb(1'b1, 7'(r), V2);
            step();
        end
        wb(1'b0, 7'd0, '0);
        checks++;
        if (inflight !== 3'd0) begin errors++; $display("FAIL lim_drain got %0d exp 0", inflight); end
    endtask

    task automatic test_nop();
        drive(1'b1, 11'h200, 3'h1, 7'd0, 7'd0, 7'd20, 18'h0, 1'b1);
        step();
        drive(1'b0, 11'h7FF, 3'h7, 7'd1, 7'd2, 7'd21, 18'h3FFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (format !== 3'h0 || op !== 11'h0 || reg_write !== 1'b0 || inflight !== 3'd1) begin
                errors++; $display("FAIL nop cycle %0d got fmt=%h op=%h rw=%b inflight=%0d exp 0/0/0/1", i, format, op, reg_write, inflight);
            end
        end
        wb(1'b1, 7'd20, V3);
        step();
        wb(1'b1, 7'd30, V4);
        step();
        wb(1'b0, 7'd0, '0);
        checks++;
        if (inflight !== 3'd0) begin errors++; $display("FAIL underflow got %0d exp 0", inflight); end
    endtask

    task automatic test_reset_midop();
        drive(1'b1, 11'h300, 3'h0, 7'd0, 7'd0, 7'd11, 18'h0, 1'b1);
        step();
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (inflight !== 3'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL midrst got inflight=%0d rw=%b exp 0/0", inflight, reg_write); end
        wb(1'b1, 7'd11, V5);
        step();
        wb(1'b0, 7'd0, '0);
        checks++;
        if (inflight !== 3'd0) begin errors++; $display("FAIL midrst_wb got inflight=%0d exp 0", inflight); end
        drive(1'b1, 11'h301, 3'h0, 7'd11, 7'd5, 7'd0, 18'h0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
        step();
        drive(1'b0, 11'h0, 3'h0, 7'd0, 7'd0, 7'd0, 18'h0, 1'b0);
        checks++;
        if (ra !== V5 || rb !== '0) begin errors++; $display("FAIL midrst_read got ra=%h rb=%h exp %h/0", ra, rb, V5); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_raw();
        test_waw();
        test_inflight_limit();
        test_nop();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
